// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Width of the latency down-counter; LATENCY-2 for LATENCY up to 15 fits.
  localparam int CNT_W = 4;

  // Index width for a storage of 'depth' words; at least one bit.
  function automatic int clog2_depth(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: DEPTH x DATA_W, one shared index for read and write.
// Latency: write commits on the rising edge, read is combinational.
// Backpressure: none; the caller decides when to write.
module dmem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents deliberately have no reset; they survive the responder's rst.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Synchronous write of one word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the MEM-stage load/store port with a fixed programmable latency.
// Latency: rsp_valid first seen LATENCY cycles after the request accept cycle.
// Backpressure: one request in flight; response held until rsp_ready, req_ready low meanwhile.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = clog2_depth(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  dmem_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_op_we;
  logic [ADDR_W-1:0] w_op_addr;
  logic [DATA_W-1:0] w_op_wdata;
  logic [IDX_W-1:0]  w_op_idx;
  logic              w_op_err;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_rsp_data;

  assign w_accept = (r_state == IDLE) && req_valid;

  // With LATENCY==1 the response is formed on the accept edge itself, so the
  // operation comes straight from the request pins; otherwise from the latch.
  assign w_op_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_op_idx   = w_op_addr[IDX_W-1:0];
  assign w_op_err   = {1'b0, w_op_addr} >= (ADDR_W + 1)'(DEPTH);

  assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                        ((r_state == WAIT) && (r_cnt == '0));

  // Stores commit on the edge that enters RESP; rst wins, so a store still
  // waiting when rst arrives is dropped.
  assign w_mem_we   = w_enter_resp && w_op_we && !w_op_err && !rst;
  assign w_rsp_data = (w_op_we || w_op_err) ? '0 : w_mem_rdata;

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_idx   (w_op_idx),
    .i_wdata (w_op_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Request/response FSM with latency counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_enter_resp) begin
        r_rsp_rdata <= w_rsp_data;
        r_rsp_err   <= w_op_err;
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction model plus directed vectors.
// Latency: checks cycle-exact response timing against the model.
// Backpressure: exercises rsp_ready stalls and held requests.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Main DUT (LATENCY 2)
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Second DUT (LATENCY 3) for the reset-during-wait scenario
  logic        b_rst = 1'b1;
  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b1;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [31:0] b_rsp_rdata;

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model of the main DUT ----------------
  bit          m_init = 0, m_pend = 0, m_resp = 0, m_rknown = 0;
  int          m_left = 0;
  logic        m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [31:0] m_mem [int];

  task automatic model_commit();
    int idx;
    idx      = int'(m_addr % 32'(DEPTH));
    m_pend   = 0;
    m_resp   = 1;
    m_err    = (m_addr >= 32'(DEPTH));
    m_rknown = 1;
    if (m_err) begin
      m_rdata = '0;
    end else if (m_we) begin
      m_mem[idx] = m_wdata;
      m_rdata    = '0;
    end else if (m_mem.exists(idx)) begin
      m_rdata = m_mem[idx];
    end else begin
      m_rknown = 0;
      m_rdata  = '0;
    end
  endtask

  // Model advances on each rising edge from the inputs seen at that edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_init = 1; m_pend = 0; m_resp = 0;
    end else if (m_resp) begin
      if (rsp_ready) m_resp = 0;
    end else if (m_pend) begin
      m_left--;
      if (m_left == 0) model_commit();
    end else if (req_valid) begin
      m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
      m_left = LAT - 1;
      if (m_left == 0) model_commit();
      else m_pend = 1;
    end
  end

  int          acc_q[$];
  int          rsph_q[$];
  logic [31:0] rsp_q[$];

  // Compare process: mid-cycle check of every output against the model.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("req_ready", 32'(req_ready), 32'(!(m_pend || m_resp)));
      chk("busy",      32'(busy),      32'(m_pend || m_resp));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("rsp_err",   32'(rsp_err),   32'(m_resp && m_err));
      if (!m_resp || m_rknown)
        chk("rsp_rdata", rsp_rdata, m_resp ? m_rdata : 32'h0);
    end
    if (req_valid && req_ready && !rst) acc_q.push_back(cyc);
    if (rsp_valid && rsp_ready && !rst) begin
      rsp_q.push_back(rsp_rdata);
      rsph_q.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers (inputs change 2ns after posedge) -----
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    acc = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
    if (!acc) chk("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic e, output int lat);
    bit got;
    got = 0; lat = 0; d = '0; e = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); lat++;
      if (rsp_valid) begin got = 1; d = rsp_rdata; e = rsp_err; end
      @(posedge clk); #2;
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic b_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
    bit got;
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = a; b_req_wdata = d;
    @(negedge clk); chk("b_req_ready_idle", 32'(b_req_ready), 32'd1);
    @(posedge clk); #2;
    b_req_valid = 1'b0;
    got = 0; lat = 0; rd = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); lat++;
      if (b_rsp_valid) begin got = 1; rd = b_rsp_rdata; end
      @(posedge clk); #2;
    end
    if (!got) chk("b_rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, n0, r0, seen;

    // Reset
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'h0);
    @(posedge clk); #2;
    rst = 1'b0; b_rst = 1'b0;

    // LATENCY 3: reset during WAIT drops the store
    b_txn(1'b1, 32'd7, 32'h0707_0707, d, lat);
    chk("b_store_lat", 32'(lat), 32'd3);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'd7; b_req_wdata = 32'hA5A5_A5A5;
    @(posedge clk); #2;
    b_req_valid = 1'b0;
    b_rst = 1'b1;
    @(posedge clk); #2;
    b_rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_rsp_valid) seen++;
    end
    chk("b_no_rsp_after_rst", 32'(seen), 32'd0);
    chk("b_busy_after_rst", 32'(b_busy), 32'd0);
    @(posedge clk); #2;
    b_txn(1'b0, 32'd7, 32'h0, d, lat);
    chk("b_addr7_old", d, 32'h0707_0707);

    // Setup values on the main DUT
    do_req(1'b1, 32'd44, 32'h4444_4444); get_rsp(d, e, lat);
    do_req(1'b1, 32'd1,  32'h1111_1111); get_rsp(d, e, lat);
    do_req(1'b1, 32'd2,  32'h2222_2222); get_rsp(d, e, lat);

    // Store then load
    do_req(1'b1, 32'd5, 32'hDEAD_BEEF); get_rsp(d, e, lat);
    chk("store_lat", 32'(lat), 32'd2);
    chk("store_rdata", d, 32'h0);
    chk("store_err", 32'(e), 32'd0);
    do_req(1'b0, 32'd5, 32'h0); get_rsp(d, e, lat);
    chk("load5_rdata", d, 32'hDEAD_BEEF);
    chk("load5_lat", 32'(lat), 32'd2);

    // Response backpressure with a held second request
    rsp_ready = 1'b0;
    do_req(1'b0, 32'd5, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd44;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      @(posedge clk); #2;
    end
    chk("bp_rsp_seen", 32'(seen), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_hold_err",   32'(rsp_err), 32'd0);
      chk("bp_req_ready",  32'(req_ready), 32'd0);
      @(posedge clk); #2;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    req_valid = 1'b0;
    if (acc_q.size() > 0 && rsph_q.size() > 0)
      chk("bp_accept_gap", 32'(acc_q[$] - rsph_q[$]), 32'd1);
    else
      chk("bp_queues", 32'd0, 32'd1);
    get_rsp(d, e, lat);
    chk("bp_second_rdata", d, 32'h4444_4444);

    // Out-of-range load and store
    do_req(1'b0, 32'd256, 32'h0); get_rsp(d, e, lat);
    chk("oor_load_err", 32'(e), 32'd1);
    chk("oor_load_rdata", d, 32'h0);
    do_req(1'b1, 32'd300, 32'h0000_1234); get_rsp(d, e, lat);
    chk("oor_store_err", 32'(e), 32'd1);
    do_req(1'b0, 32'd44, 32'h0); get_rsp(d, e, lat);
    chk("alias44_rdata", d, 32'h4444_4444);

    // Reset while the store response is pending keeps the store
    rsp_ready = 1'b0;
    do_req(1'b1, 32'd9, 32'h9999_9999);
    @(posedge clk); #2;
    @(negedge clk);
    chk("resp_pending", 32'(rsp_valid), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_resp_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    do_req(1'b0, 32'd9, 32'h0); get_rsp(d, e, lat);
    chk("resp_store_kept", d, 32'h9999_9999);

    // Back-to-back loads with req_valid held high
    n0 = acc_q.size(); r0 = rsp_q.size();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd1;
    for (int k = 0; k < 40 && acc_q.size() == n0; k++) begin @(posedge clk); #2; end
    req_addr = 32'd2;
    for (int k = 0; k < 40 && acc_q.size() == n0 + 1; k++) begin @(posedge clk); #2; end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("b2b_accepts", 32'(acc_q.size() - n0), 32'd2);
    chk("b2b_rsps", 32'(rsp_q.size() - r0), 32'd2);
    if (acc_q.size() >= n0 + 2 && rsp_q.size() >= r0 + 2) begin
      chk("b2b_spacing", 32'(acc_q[n0+1] - acc_q[n0]), 32'd3);
      chk("b2b_first",  rsp_q[r0],   32'h1111_1111);
      chk("b2b_second", rsp_q[r0+1], 32'h2222_2222);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
